// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Parametrised program counter for the MIPS fetch stage.
//                Provides a configurable width, reset vector and step, a
//                synchronous load for branches/jumps, and an optional
//                hardware return-address stack for call/return.
//
//                Optional feature macro:
//                  PC_SEQ_STACK_EN  - when defined, builds a circular
//                                     STACK_DEPTH x WIDTH return stack.
//                                     When undefined, call behaves as load,
//                                     ret is ignored and the stack flags are
//                                     tied to their empty-stack values.
//
//  Ports       : clk          - rising-edge clock
//                reset        - synchronous reset, active low
//                pc_en        - 1 = counter may change this cycle
//                load         - jump to load_addr
//                load_addr    - branch/jump/call target
//                call         - push count+STEP and jump to load_addr
//                ret          - pop return address into count
//                count        - current PC (registered)
//                stack_empty  - stack holds 0 entries (registered)
//                stack_full   - stack holds STACK_DEPTH entries (registered)
//                stack_ovf    - one-cycle pulse: call while full
//                stack_unf    - one-cycle pulse: ret while empty
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int WIDTH       = 32,
    parameter int RESET_VEC   = 0,
    parameter int STEP        = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] count,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_ovf,
    output logic             stack_unf
);

    // Parameters are sized to the datapath once so that all arithmetic
    // below wraps naturally modulo 2**WIDTH.
    localparam logic [WIDTH-1:0] c_RESET_VEC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] c_STEP      = WIDTH'(STEP);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_count_inc;

    // Sequential successor; also the return address pushed on a call.
    assign w_count_inc = r_count + c_STEP;

    assign count = r_count;

`ifdef PC_SEQ_STACK_EN

    localparam int               c_PTR_W = $clog2(STACK_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(STACK_DEPTH);

    // Circular buffer: r_wr_ptr is the next slot to write, the top of stack
    // sits one slot below it. r_occ counts valid entries (0..STACK_DEPTH).
    // When full, r_wr_ptr already points at the oldest entry, so a push
    // simply overwrites it while occupancy saturates at STACK_DEPTH.
    logic [WIDTH-1:0]   r_stack [STACK_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_occ;
    logic               r_empty;
    logic               r_full;
    logic               r_ovf;
    logic               r_unf;

    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [WIDTH-1:0]   w_top;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_PTR_W:0]   w_occ_nxt;
    logic               w_push;
    logic               w_ovf_nxt;
    logic               w_unf_nxt;
    logic               w_is_empty;
    logic               w_is_full;

    assign w_rd_ptr   = r_wr_ptr - 1'b1;
    assign w_top      = r_stack[w_rd_ptr];
    assign w_is_empty = (r_occ == '0);
    assign w_is_full  = (r_occ == c_DEPTH);

    // Command decode: exactly one action per enabled cycle with priority
    // ret > call > load > increment.
    always_comb begin
        w_count_nxt = r_count;
        w_ptr_nxt   = r_wr_ptr;
        w_occ_nxt   = r_occ;
        w_push      = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        if (pc_en) begin
            if (ret) begin
                if (w_is_empty) begin
                    // Underflow restarts the program from the reset vector.
                    w_count_nxt = c_RESET_VEC;
                    w_unf_nxt   = 1'b1;
                end else begin
                    w_count_nxt = w_top;
                    w_ptr_nxt   = w_rd_ptr;
                    w_occ_nxt   = r_occ - 1'b1;
                end
            end else if (call) begin
                w_push      = 1'b1;
                w_count_nxt = load_addr;
                w_ptr_nxt   = r_wr_ptr + 1'b1;
                if (w_is_full) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_occ_nxt = r_occ + 1'b1;
                end
            end else if (load) begin
                w_count_nxt = load_addr;
            end else begin
                w_count_nxt = w_count_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count  <= c_RESET_VEC;
            r_wr_ptr <= '0;
            r_occ    <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_ptr_nxt;
            r_occ    <= w_occ_nxt;
            // Flags reflect occupancy after this cycle's update.
            r_empty  <= (w_occ_nxt == '0);
            r_full   <= (w_occ_nxt == c_DEPTH);
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
        end
    end

    // Entry storage carries no reset; stale contents are unreachable once
    // the pointer/occupancy are cleared.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_stack[r_wr_ptr] <= w_count_inc;
        end
    end

    assign stack_empty = r_empty;
    assign stack_full  = r_full;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;

`else

    // No return stack: call is a plain jump, ret is ignored.
    logic       w_unused_ret;
    logic [1:0] w_unused_cfg;

    assign w_unused_ret = ret;
    assign w_unused_cfg = 2'(STACK_DEPTH);

    always_comb begin
        w_count_nxt = r_count;
        if (pc_en) begin
            if (call || load) begin
                w_count_nxt = load_addr;
            end else begin
                w_count_nxt = w_count_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= c_RESET_VEC;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_ovf   = 1'b0;
    assign stack_unf   = 1'b0;

`endif

endmodule
`default_nettype wire
